// File: rtl/jtag_param_sequencer.sv
// -----------------------------------------------------------------------------
// jtag_param_sequencer
//
// Outer command sequencer behind the JTAG-UART decoder. It takes decoded
// instructions, gathers the two argument bytes of a parameter-update command
// and commits them as a single register-write strobe. Bulk-transfer codes
// (1..9) are handed to the frame-loader path, and the sequencer waits for that
// path to finish. Each argument byte must arrive within TIMEOUT_CYCLES cycles.
//
// Ports
//   iCLK, iRST_N            clock, asynchronous active-low reset
//   iNEW_INSTR / iINSTR     decoder instruction flag and 7-bit code
//   iNEW_DATA  / iDATA      decoder data flag and byte
//   oACK_INSTR / oACK_DATA  one-cycle consume pulses back to the decoder
//   oIDLE_TO_TAKE_COMMAND   high while in IDLE or ERROR
//   oPARAM_WE/SEL/VALUE     register-write strobe, target (0..5), {hi, lo}
//   oHANDOFF_START/INSTR    bulk-path start pulse and the code handed off
//   iHANDOFF_DONE           bulk path finished (level or pulse)
//   oERROR                  sticky error flag, cleared only by CODE_IDLE
//   oBUSY                   high outside IDLE and ERROR
// -----------------------------------------------------------------------------
module jtag_param_sequencer #(
    parameter logic [6:0] CODE_IDLE        = 7'd0,
    parameter logic [6:0] CODE_ACK         = 7'd126,
    parameter logic [6:0] CODE_ERROR       = 7'd127,
    parameter logic [6:0] CODE_OFS_H       = 7'd10,
    parameter logic [6:0] CODE_OFS_V       = 7'd11,
    parameter logic [6:0] CODE_GALVO_X     = 7'd20,
    parameter logic [6:0] CODE_GALVO_Y     = 7'd21,
    parameter logic [6:0] CODE_NUM_FRAMES  = 7'd30,
    parameter logic [6:0] CODE_CYC_DISPLAY = 7'd31,
    parameter int         TIMEOUT_CYCLES   = 50_000_000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iNEW_INSTR,
    input  logic [6:0]  iINSTR,
    input  logic        iNEW_DATA,
    input  logic [7:0]  iDATA,
    output logic        oACK_INSTR,
    output logic        oACK_DATA,
    output logic        oIDLE_TO_TAKE_COMMAND,
    output logic        oPARAM_WE,
    output logic [2:0]  oPARAM_SEL,
    output logic [15:0] oPARAM_VALUE,
    output logic        oHANDOFF_START,
    output logic [6:0]  oHANDOFF_INSTR,
    input  logic        iHANDOFF_DONE,
    output logic        oERROR,
    output logic        oBUSY
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_HI  = 3'd1,
        ST_GET_LO  = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_HANDOFF = 3'd4,
        ST_ERROR   = 3'd5
    } stateT;

    // Maps a parameter-update code to {hit, sel}; hit=0 for every other code.
    function automatic logic [3:0] decodeParam(input logic [6:0] code);
        logic [3:0] res;
        if (code == CODE_OFS_H) begin
            res = {1'b1, 3'd0};
        end else if (code == CODE_OFS_V) begin
            res = {1'b1, 3'd1};
        end else if (code == CODE_GALVO_X) begin
            res = {1'b1, 3'd2};
        end else if (code == CODE_GALVO_Y) begin
            res = {1'b1, 3'd3};
        end else if (code == CODE_NUM_FRAMES) begin
            res = {1'b1, 3'd4};
        end else if (code == CODE_CYC_DISPLAY) begin
            res = {1'b1, 3'd5};
        end else begin
            res = {1'b0, 3'd0};
        end
        return res;
    endfunction

    stateT         state;
    stateT         nextState;
    logic [TW-1:0] timer;
    logic [7:0]    hiByte;
    logic [2:0]    pendingSel;
    logic [15:0]   pendingValue;

    logic       instrAvail;
    logic       dataAvail;
    logic       timerExpired;
    logic [3:0] paramInfo;
    logic       isHandoffCode;

    logic ackInstrNext;
    logic ackDataNext;
    logic weNext;
    logic startNext;
    logic latchSel;
    logic latchHi;
    logic latchLo;
    logic clearTimer;

    // The decoder drops its flag one cycle after our ack, so a flag seen while
    // our own ack is still high is the item we already took.
    assign instrAvail    = iNEW_INSTR && !oACK_INSTR;
    assign dataAvail     = iNEW_DATA && !oACK_DATA;
    assign timerExpired  = (timer == TIMER_LAST);
    assign paramInfo     = decodeParam(iINSTR);
    assign isHandoffCode = (iINSTR >= 7'd1) && (iINSTR <= 7'd9);

    // Next-state and strobe decode; instructions always take priority over data.
    always_comb begin
        nextState    = state;
        ackInstrNext = 1'b0;
        ackDataNext  = 1'b0;
        weNext       = 1'b0;
        startNext    = 1'b0;
        latchSel     = 1'b0;
        latchHi      = 1'b0;
        latchLo      = 1'b0;
        clearTimer   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instrAvail) begin
                    ackInstrNext = 1'b1;
                    if (paramInfo[3]) begin
                        latchSel   = 1'b1;
                        clearTimer = 1'b1;
                        nextState  = ST_GET_HI;
                    end else if ((iINSTR == CODE_IDLE) || (iINSTR == CODE_ACK)) begin
                        nextState = ST_IDLE;
                    end else if ((iINSTR != CODE_ERROR) && isHandoffCode) begin
                        startNext = 1'b1;
                        nextState = ST_HANDOFF;
                    end else begin
                        nextState = ST_ERROR;
                    end
                end else if (dataAvail) begin
                    ackDataNext = 1'b1;
                    nextState   = ST_IDLE;
                end else begin
                    nextState = ST_IDLE;
                end
            end
            ST_GET_HI, ST_GET_LO: begin
                if (instrAvail) begin
                    ackInstrNext = 1'b1;
                    if (iINSTR == CODE_IDLE) begin
                        nextState = ST_IDLE;
                    end else if (iINSTR == CODE_ACK) begin
                        nextState = timerExpired ? ST_ERROR : state;
                    end else begin
                        nextState = ST_ERROR;
                    end
                end else if (dataAvail) begin
                    // A byte arriving on the expiry cycle still counts.
                    ackDataNext = 1'b1;
                    if (state == ST_GET_HI) begin
                        latchHi    = 1'b1;
                        clearTimer = 1'b1;
                        nextState  = ST_GET_LO;
                    end else begin
                        latchLo   = 1'b1;
                        nextState = ST_COMMIT;
                    end
                end else if (timerExpired) begin
                    nextState = ST_ERROR;
                end else begin
                    nextState = state;
                end
            end
            ST_COMMIT: begin
                weNext    = 1'b1;
                nextState = ST_IDLE;
            end
            ST_HANDOFF: begin
                // Data bytes are left for the bulk path to read.
                if (instrAvail) begin
                    ackInstrNext = 1'b1;
                    if (iINSTR == CODE_IDLE) begin
                        nextState = ST_IDLE;
                    end else if (iINSTR == CODE_ACK) begin
                        nextState = ST_HANDOFF;
                    end else begin
                        nextState = ST_ERROR;
                    end
                end else if (iHANDOFF_DONE) begin
                    nextState = ST_IDLE;
                end else begin
                    nextState = ST_HANDOFF;
                end
            end
            ST_ERROR: begin
                if (instrAvail) begin
                    ackInstrNext = 1'b1;
                    nextState    = (iINSTR == CODE_IDLE) ? ST_IDLE : ST_ERROR;
                end else if (dataAvail) begin
                    ackDataNext = 1'b1;
                    nextState   = ST_ERROR;
                end else begin
                    nextState = ST_ERROR;
                end
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    // State register and the argument byte timer.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= nextState;
            if (clearTimer) begin
                timer <= '0;
            end else if ((state == ST_GET_HI) || (state == ST_GET_LO)) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
        end
    end

    // Argument capture; the outputs only change on the commit cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hiByte       <= 8'h00;
            pendingSel   <= 3'd0;
            pendingValue <= 16'h0000;
            oPARAM_SEL   <= 3'd0;
            oPARAM_VALUE <= 16'h0000;
        end else begin
            if (latchSel) begin
                pendingSel <= paramInfo[2:0];
            end
            if (latchHi) begin
                hiByte <= iDATA;
            end
            if (latchLo) begin
                pendingValue <= {hiByte, iDATA};
            end
            if (weNext) begin
                oPARAM_SEL   <= pendingSel;
                oPARAM_VALUE <= pendingValue;
            end
        end
    end

    // Registered handshake strobes and status flags.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oACK_INSTR            <= 1'b0;
            oACK_DATA             <= 1'b0;
            oPARAM_WE             <= 1'b0;
            oHANDOFF_START        <= 1'b0;
            oHANDOFF_INSTR        <= 7'd0;
            oERROR                <= 1'b0;
            oBUSY                 <= 1'b0;
            oIDLE_TO_TAKE_COMMAND <= 1'b1;
        end else begin
            oACK_INSTR     <= ackInstrNext;
            oACK_DATA      <= ackDataNext;
            oPARAM_WE      <= weNext;
            oHANDOFF_START <= startNext;
            if (startNext) begin
                oHANDOFF_INSTR <= iINSTR;
            end
            oERROR                <= (nextState == ST_ERROR);
            oBUSY                 <= (nextState != ST_IDLE) && (nextState != ST_ERROR);
            oIDLE_TO_TAKE_COMMAND <= (nextState == ST_IDLE) || (nextState == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_jtag_param_sequencer.sv
module tb_jtag_param_sequencer;

    localparam int TMO = 16;
    localparam int M_IDLE = 0, M_COLLECT = 1, M_WRITE = 2, M_BULK = 3, M_ERROR = 4;

    logic        iCLK = 1'b0;
    logic        rstN;
    logic        newInstr, newData, handoffDone;
    logic [6:0]  instrVal;
    logic [7:0]  dataVal;
    logic        oACK_INSTR, oACK_DATA, oIDLE, oPARAM_WE, oHANDOFF_START, oERROR, oBUSY;
    logic [2:0]  oPARAM_SEL;
    logic [15:0] oPARAM_VALUE;
    logic [6:0]  oHANDOFF_INSTR;

    int vectors = 0;
    int miscompares = 0;
    bit checkEn = 1'b0;

    jtag_param_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .iCLK(iCLK), .iRST_N(rstN),
        .iNEW_INSTR(newInstr), .iINSTR(instrVal),
        .iNEW_DATA(newData), .iDATA(dataVal),
        .oACK_INSTR(oACK_INSTR), .oACK_DATA(oACK_DATA),
        .oIDLE_TO_TAKE_COMMAND(oIDLE),
        .oPARAM_WE(oPARAM_WE), .oPARAM_SEL(oPARAM_SEL), .oPARAM_VALUE(oPARAM_VALUE),
        .oHANDOFF_START(oHANDOFF_START), .oHANDOFF_INSTR(oHANDOFF_INSTR),
        .iHANDOFF_DONE(handoffDone),
        .oERROR(oERROR), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- decoder model: flag drops one cycle after the ack ------
    logic [6:0] instrQ[$];
    logic [7:0] dataQ[$];
    bit clrI = 1'b0, clrD = 1'b0;

    always @(negedge iCLK) begin
        if (!rstN) begin
            newInstr = 1'b0; newData = 1'b0; clrI = 1'b0; clrD = 1'b0;
        end else begin
            if (clrI) begin newInstr = 1'b0; clrI = 1'b0; end
            if (clrD) begin newData = 1'b0; clrD = 1'b0; end
            if (newInstr && oACK_INSTR) clrI = 1'b1;
            if (newData && oACK_DATA) clrD = 1'b1;
            if (!newInstr && instrQ.size() > 0) begin instrVal = instrQ.pop_front(); newInstr = 1'b1; end
            if (!newData && dataQ.size() > 0) begin dataVal = dataQ.pop_front(); newData = 1'b1; end
        end
    end

    // ---------------- behavioural model (transaction view) -------------------
    int          mMode, mGot, mWait, startMode, sel;
    logic [15:0] mArg;
    logic [2:0]  mSel;
    bit          pI, pD, tookByte;
    logic        eAckI, eAckD, eWe, eStart, eErr, eBusy, eIdle;
    logic [2:0]  eSel;
    logic [15:0] eVal;
    logic [6:0]  eHI;

    function automatic int selFor(input logic [6:0] c);
        case (c)
            7'd10: return 0;
            7'd11: return 1;
            7'd20: return 2;
            7'd21: return 3;
            7'd30: return 4;
            7'd31: return 5;
            default: return -1;
        endcase
    endfunction

    always @(posedge iCLK or negedge rstN) begin
        if (!rstN) begin
            mMode = M_IDLE; mGot = 0; mWait = 0; mArg = 16'h0; mSel = 3'd0;
            eAckI = 0; eAckD = 0; eWe = 0; eStart = 0; eErr = 0; eBusy = 0; eIdle = 1;
            eSel = 3'd0; eVal = 16'h0; eHI = 7'd0;
        end else begin
            pI = newInstr && !eAckI;
            pD = newData && !eAckD;
            eAckI = 0; eAckD = 0; eWe = 0; eStart = 0; tookByte = 0;
            startMode = mMode;
            if (mMode == M_WRITE) begin
                eWe = 1; eSel = mSel; eVal = mArg; mMode = M_IDLE;
            end else if (pI) begin
                eAckI = 1;
                sel = selFor(instrVal);
                if (mMode == M_IDLE) begin
                    if (sel >= 0) begin
                        mSel = sel[2:0]; mGot = 0; mWait = 0; mMode = M_COLLECT; tookByte = 1;
                    end else if (instrVal == 7'd0 || instrVal == 7'd126) begin
                        mMode = M_IDLE;
                    end else if (instrVal >= 7'd1 && instrVal <= 7'd9) begin
                        mMode = M_BULK; eStart = 1; eHI = instrVal;
                    end else begin
                        mMode = M_ERROR;
                    end
                end else if (mMode == M_ERROR) begin
                    if (instrVal == 7'd0) mMode = M_IDLE;
                end else begin
                    if (instrVal == 7'd0) mMode = M_IDLE;
                    else if (instrVal != 7'd126) mMode = M_ERROR;
                end
            end else if (pD && mMode != M_BULK) begin
                eAckD = 1;
                if (mMode == M_COLLECT) begin
                    mArg = {mArg[7:0], dataVal}; mGot++; mWait = 0; tookByte = 1;
                    if (mGot == 2) mMode = M_WRITE;
                end
            end else if (mMode == M_BULK && handoffDone) begin
                mMode = M_IDLE;
            end
            if (startMode == M_COLLECT && mMode == M_COLLECT && !tookByte) begin
                mWait++;
                if (mWait >= TMO) mMode = M_ERROR;
            end
            eErr  = (mMode == M_ERROR);
            eBusy = (mMode == M_COLLECT || mMode == M_WRITE || mMode == M_BULK);
            eIdle = (mMode == M_IDLE || mMode == M_ERROR);
        end
    end

    // ---------------- per-cycle compare + event monitor ----------------------
    int cyc = 0, nAckI = 0, nAckD = 0, nWe = 0, nStart = 0;
    int lastAckDCyc = 0, weCyc = 0, errRiseCyc = 0;
    logic [2:0]  lastSel;
    logic [15:0] lastVal;
    logic        prevErr = 1'b0;

    always @(negedge iCLK) begin
        cyc++;
        if (checkEn)
            check("cycle", {oACK_INSTR, oACK_DATA, oPARAM_WE, oPARAM_SEL, oPARAM_VALUE,
                            oHANDOFF_START, oHANDOFF_INSTR, oERROR, oBUSY, oIDLE},
                           {eAckI, eAckD, eWe, eSel, eVal, eStart, eHI, eErr, eBusy, eIdle});
        if (oACK_INSTR === 1'b1) nAckI++;
        if (oACK_DATA === 1'b1) begin nAckD++; lastAckDCyc = cyc; end
        if (oPARAM_WE === 1'b1) begin nWe++; weCyc = cyc; lastSel = oPARAM_SEL; lastVal = oPARAM_VALUE; end
        if (oHANDOFF_START === 1'b1) nStart++;
        if (oERROR === 1'b1 && prevErr !== 1'b1) errRiseCyc = cyc;
        prevErr = oERROR;
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic clearCounts();
        nAckI = 0; nAckD = 0; nWe = 0; nStart = 0;
    endtask

    task automatic timeoutFail(input string tag, input int budget);
        vectors++;
        miscompares++;
        $display("FAIL %s: condition not reached within %0d cycles", tag, budget);
    endtask

    task automatic waitQuiet(input string tag, input int budget);
        int n = 0;
        while (!(instrQ.size() == 0 && dataQ.size() == 0 && !newInstr && !newData && oBUSY === 1'b0)
               && n < budget) begin
            tick(1); n++;
        end
        if (n >= budget) timeoutFail(tag, budget);
        tick(2);
    endtask

    task automatic waitDataAck(input string tag, input int budget);
        int n = 0;
        while (oACK_DATA !== 1'b1 && n < budget) begin tick(1); n++; end
        if (n >= budget) timeoutFail(tag, budget);
    endtask

    // ---------------- directed tests ------------------------------------------
    initial begin
        rstN = 1'b0; newInstr = 1'b0; newData = 1'b0; instrVal = 7'd0; dataVal = 8'h00;
        handoffDone = 1'b0;
        tick(2);
        checkEn = 1'b1;
        check("reset-outputs", {oACK_INSTR, oACK_DATA, oPARAM_WE, oPARAM_SEL, oPARAM_VALUE,
                                oHANDOFF_START, oHANDOFF_INSTR, oERROR, oBUSY, oIDLE}, 64'h1);
        rstN = 1'b1;
        tick(2);

        // 1/2: GALVO_X 0x12 0x34, instruction and data pending together
        clearCounts();
        instrQ.push_back(7'd20); dataQ.push_back(8'h12); dataQ.push_back(8'h34);
        waitQuiet("t1-quiet", 60);
        check("t1-instr-acks", nAckI, 1);
        check("t1-data-acks", nAckD, 2);
        check("t1-we-count", nWe, 1);
        check("t1-we-latency", weCyc - lastAckDCyc, 1);
        check("t1-sel", lastSel, 3'd2);
        check("t1-value", lastVal, 16'h1234);
        check("t1-idle", oIDLE, 1'b1);

        // 3: OFS_V 0xAB then silence -> timeout after 16 cycles
        clearCounts();
        instrQ.push_back(7'd11); dataQ.push_back(8'hAB);
        waitDataAck("t3-hi-ack", 30);
        tick(24);
        check("t3-timeout-cycles", errRiseCyc - lastAckDCyc, 16);
        check("t3-no-we", nWe, 0);
        check("t3-error", oERROR, 1'b1);
        instrQ.push_back(7'd50); dataQ.push_back(8'h55);
        tick(8);
        check("t3-error-sticky", oERROR, 1'b1);
        instrQ.push_back(7'd0);
        waitQuiet("t3-clear", 30);
        check("t3-error-cleared", oERROR, 1'b0);
        check("t3-idle", oIDLE, 1'b1);

        // 4: NUM_FRAMES 0x01 then CODE_IDLE aborts
        clearCounts();
        instrQ.push_back(7'd30); dataQ.push_back(8'h01);
        waitDataAck("t4-hi-ack", 30);
        instrQ.push_back(7'd0);
        waitQuiet("t4-quiet", 30);
        check("t4-no-we", nWe, 0);
        check("t4-no-error", oERROR, 1'b0);
        check("t4-idle", oIDLE, 1'b1);

        // 5: handoff code 3, data not acked until done
        clearCounts();
        instrQ.push_back(7'd3); dataQ.push_back(8'h99); dataQ.push_back(8'h98);
        begin
            int n = 0;
            while (oHANDOFF_START !== 1'b1 && n < 20) begin tick(1); n++; end
            if (n >= 20) timeoutFail("t5-start", 20);
        end
        check("t5-handoff-instr", oHANDOFF_INSTR, 7'd3);
        check("t5-busy", oBUSY, 1'b1);
        tick(6);
        check("t5-no-data-ack", nAckD, 0);
        handoffDone = 1'b1;
        tick(1);
        handoffDone = 1'b0;
        check("t5-idle-after-done", oIDLE, 1'b1);
        waitQuiet("t5-quiet", 30);
        check("t5-start-count", nStart, 1);
        check("t5-data-discarded", nAckD, 2);

        // byte arriving on the expiry cycle wins
        clearCounts();
        instrQ.push_back(7'd21); dataQ.push_back(8'hC3);
        waitDataAck("t5b-hi-ack", 30);
        repeat (TMO - 1) @(posedge iCLK);
        #1;
        dataQ.push_back(8'h5A);
        waitQuiet("t5b-quiet", 30);
        check("t5b-we", nWe, 1);
        check("t5b-value", lastVal, 16'hC35A);
        check("t5b-sel", lastSel, 3'd3);
        check("t5b-no-error", oERROR, 1'b0);

        // unknown code from IDLE -> ERROR, CODE_IDLE recovers
        instrQ.push_back(7'd50);
        tick(5);
        check("unknown-error", oERROR, 1'b1);
        instrQ.push_back(7'd0);
        waitQuiet("unknown-clear", 30);
        check("unknown-cleared", oERROR, 1'b0);

        // 6: async reset mid-GET_LO, then OFS_H 0x00 0x05
        clearCounts();
        instrQ.push_back(7'd20); dataQ.push_back(8'h77);
        waitDataAck("t6-hi-ack", 30);
        tick(3);
        rstN = 1'b0;
        #1;
        check("t6-async-reset", {oACK_INSTR, oACK_DATA, oPARAM_WE, oPARAM_SEL, oPARAM_VALUE,
                                 oHANDOFF_START, oHANDOFF_INSTR, oERROR, oBUSY, oIDLE}, 64'h1);
        instrQ.delete(); dataQ.delete();
        tick(2);
        rstN = 1'b1;
        tick(1);
        clearCounts();
        instrQ.push_back(7'd10); dataQ.push_back(8'h00); dataQ.push_back(8'h05);
        waitQuiet("t6-quiet", 60);
        check("t6-we", nWe, 1);
        check("t6-sel", lastSel, 3'd0);
        check("t6-value", lastVal, 16'h0005);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
